// File: rtl/maxnet_host_seq_if.sv
// maxnet_host_seq_if: operand and response valid/ready streams between a host and the sequencer.
//  in_valid/in_data/in_ready        operand beats, host -> sequencer
//  out_valid/out_data/out_timeout   response, sequencer -> host
//  out_ready                        host accepts the response
interface maxnet_host_seq_if #(parameter int WIDTH = 5);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_timeout;
  logic             out_ready;
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_timeout
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_timeout
  );
endinterface

// File: rtl/maxnet_host_seq.sv
// maxnet_host_seq: packs four operand beats into the compare core, restarts it, and returns its result or a timeout.
//  clk, rst_n            clock and asynchronous active-low reset
//  s_host                operand/response streams (slave side)
//  o_core_rst            one-cycle restart pulse to the core
//  o_core_b0..o_core_b3  operand slots 0..3
//  i_core_done           core finished, i_core_result valid
//  o_busy                high whenever not collecting operands
module maxnet_host_seq #(
  parameter int WIDTH   = 5,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  maxnet_host_seq_if.slave s_host,
  output logic             o_core_rst,
  output logic [WIDTH-1:0] o_core_b0,
  output logic [WIDTH-1:0] o_core_b1,
  output logic [WIDTH-1:0] o_core_b2,
  output logic [WIDTH-1:0] o_core_b3,
  input  logic             i_core_done,
  input  logic [WIDTH-1:0] i_core_result,
  output logic             o_busy
);
  typedef enum logic [2:0] {COLLECT, START, GUARD, RUN, RESP} state_t;
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);
  state_t           r_state, w_next;
  logic [1:0]       r_idx;
  logic [WIDTH-1:0] r_slot [4];
  logic [CNT_W-1:0] r_timer;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid, r_out_timeout;
  logic             w_beat, w_expire, w_finish;
  assign s_host.in_ready    = (r_state == COLLECT) && rst_n;
  assign s_host.out_valid   = r_out_valid;
  assign s_host.out_data    = r_out_data;
  assign s_host.out_timeout = r_out_timeout;
  assign w_beat   = s_host.in_valid && s_host.in_ready;
  assign w_expire = r_timer == LP_LAST;
  // done takes priority over an expiring timer in the same cycle
  assign w_finish = (r_state == RUN) && (i_core_done || w_expire);
  // restart is a pure decode of START so reset removes it without waiting for a clock
  assign o_core_rst = r_state == START;
  assign o_busy     = r_state != COLLECT;
  assign o_core_b0  = r_slot[0];
  assign o_core_b1  = r_slot[1];
  assign o_core_b2  = r_slot[2];
  assign o_core_b3  = r_slot[3];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= COLLECT;
    else r_state <= w_next;
  // GUARD burns one cycle so a done left over from the previous run is never sampled
  always_comb begin
    w_next = r_state;
    case (r_state)
      COLLECT: w_next = (w_beat && r_idx == 2'd3) ? START : COLLECT;
      START:   w_next = GUARD;
      GUARD:   w_next = RUN;
      RUN:     w_next = w_finish ? RESP : RUN;
      RESP:    w_next = s_host.out_ready ? COLLECT : RESP;
      default: w_next = COLLECT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_idx         <= '0;
      r_slot        <= '{default: '0};
      r_timer       <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_timeout <= 1'b0;
    end else begin
      if (w_beat) begin
        r_slot[r_idx] <= s_host.in_data;
        r_idx         <= r_idx + 2'd1;
      end
      r_timer <= (r_state == START) ? '0 :
                 (r_state == GUARD) ? CNT_W'(1) :
                 (r_state == RUN)   ? r_timer + CNT_W'(1) : r_timer;
      if (w_finish) begin
        r_out_valid   <= 1'b1;
        r_out_data    <= i_core_done ? i_core_result : '0;
        r_out_timeout <= !i_core_done;
      end
      if (r_state == RESP && s_host.out_ready) begin
        r_out_valid   <= 1'b0;
        r_out_timeout <= 1'b0;
      end
    end
endmodule
